vga_fb_scanout: RTL
===================

// Module: vga_fb_scanout
// PURPOSE
//  Parametrised VGA scan-out engine: built-in programmable sync timing, framebuffer read-address
//  generation with pixel replication, an internal 256x24 palette or direct RGB332 expansion,
//  and sync/blank delayed to match read latency. Sits between a 2-port framebuffer RAM and the DAC.
// PARAMETERS
//  H_ACTIVE 640 | H_FP 16 | H_SYNC 96 | H_BP 48  : horizontal timing, pixel clocks
//  V_ACTIVE 480 | V_FP 10 | V_SYNC 2  | V_BP 33  : vertical timing, lines
//  HS_POL 0 | VS_POL 0 : sync active level (0 = active-low)
//  SCALE_LOG2 0  : pixel/line replication 2^SCALE_LOG2, legal 0..2
//  ADDR_W 19     : framebuffer address width
//  RD_LAT 2      : framebuffer read latency in clocks, legal 1..4
//  MODE 0        : 0 = 8-bit index through palette, 1 = direct RGB332
// PORTS
//  iVGA_CLK    in  1      pixel clock, all logic on rising edge
//  iRST_n      in  1      asynchronous active-low reset
//  iFB_BASE    in  ADDR_W frame base address, sampled once per frame
//  oRD_ADDR    out ADDR_W framebuffer read address (registered)
//  iRD_DATA    in  8      framebuffer data, valid RD_LAT clocks after oRD_ADDR
//  iPAL_WE     in  1      palette write enable (ignored when MODE=1)
//  iPAL_ADDR   in  8      palette write index
//  iPAL_DATA   in  24     palette entry {R,G,B}
//  oR/oG/oB    out 8 each pixel colour, 0 when blanked
//  oHS / oVS   out 1      syncs at HS_POL / VS_POL active level
//  oBLANK_n    out 1      1 = active video
//  oFRAME_START out 1     one-cycle pulse when counters are at (0,0), undelayed
// BEHAVIOUR
//  - Reset: h=v=0, oRD_ADDR=0, colours 0, oBLANK_n=0, oHS=!HS_POL, oVS=!VS_POL, delay lines
//    cleared, base=0. Palette contents not reset.
//  - h counts 0..H_TOT-1 (H_TOT=sum of H_*); v increments when h wraps, 0..V_TOT-1.
//    Line order: active, FP, sync, BP. HS active for h in [H_ACTIVE+H_FP, +H_SYNC); same for V.
//  - Active = h<H_ACTIVE && v<V_ACTIVE.
//  - Base latch: iFB_BASE sampled at (H_TOT-1,V_TOT-1); mid-frame changes apply next frame.
//  - Address, W=H_ACTIVE>>SCALE_LOG2: addr = base + (v>>S)*W + (h>>S), built incrementally
//    (row-start reg + column offset, no multiplier). Each address held 2^S clocks; each source
//    row repeated 2^S lines. Outside active region oRD_ADDR holds its last value.
//  - Pipeline: stage A registers oRD_ADDR; RD_LAT memory clocks; stage C palette read
//    (read-before-write on same-index collision) or RGB332 expansion; stage D output register.
//    oR/oG/oB, oHS, oVS, oBLANK_n for position (h,v) appear exactly LAT=RD_LAT+3 clocks after
//    counters hold (h,v); sync/blank go through a LAT-deep shift register.
//  - Blanked positions force colour 0 at stage D regardless of iRD_DATA.
//  - RGB332: d[7:5]=r,d[4:2]=g,d[1:0]=b; R={r,r,r[2:1]}, G={g,g,g[2:1]}, B={b,b,b,b}.
//  - Palette writes accepted every clock, including during active video.
//  - Reset mid-frame: all counters/pipeline return to reset state next edge; timing restarts at (0,0).
// TESTING
//  1 Defaults, release reset: oHS low exactly 96 clocks per 800-clock line; oVS low 2 lines
//    per 525-line frame; oFRAME_START period 420000 clocks.
//  2 MODE=0,S=0,base=0x100, RAM returns addr[7:0], palette[i]={i,~i,i}: first active output
//    at LAT=5 after (0,0), R=0x00,G=0xFF,B=0x00; oRD_ADDR=0x100 + 640*v + h.
//  3 SCALE_LOG2=1: oRD_ADDR sequence 0,0,1,1,...; lines 0 and 1 identical; line 2 starts at 320.
//  4 MODE=1, data 0xE0 -> RGB FF/00/00; 0x1C -> 00/FF/00; 0x03 -> 00/00/FF; blanked pixels -> 0.
//  5 Change iFB_BASE 0x0 -> 0x4000 at v=100: rest of frame uses 0x0, next frame row 0 at 0x4000.
//  6 Assert iRST_n low at (h=300,v=200) for 3 clocks: outputs at reset values, restart at (0,0),
//    first oFRAME_START one clock after release.

Source files
------------

// File: rtl/vga_fb_scanout.sv
// VGA scan-out engine: programmable sync timing, replicated framebuffer addressing,
// palette or RGB332 colour stage, and sync/blank delayed to match the read pipeline.
module vga_fb_scanout #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter bit HS_POL     = 1'b0,
   parameter bit VS_POL     = 1'b0,
   parameter int SCALE_LOG2 = 0,
   parameter int ADDR_W     = 19,
   parameter int RD_LAT     = 2,
   parameter int MODE       = 0
) (
   input  logic              iVGA_CLK,
   input  logic              iRST_n,
   input  logic [ADDR_W-1:0] iFB_BASE,
   output logic [ADDR_W-1:0] oRD_ADDR,
   input  logic [7:0]        iRD_DATA,
   input  logic              iPAL_WE,
   input  logic [7:0]        iPAL_ADDR,
   input  logic [23:0]       iPAL_DATA,
   output logic [7:0]        oR,
   output logic [7:0]        oG,
   output logic [7:0]        oB,
   output logic              oHS,
   output logic              oVS,
   output logic              oBLANK_n,
   output logic              oFRAME_START
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);
   localparam int LAT   = RD_LAT + 3;
   localparam int W     = H_ACTIVE >> SCALE_LOG2;

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [1:0]    REP_LAST = 2'((1 << SCALE_LOG2) - 1);

   logic              run;
   logic [HW-1:0]     h;
   logic [VW-1:0]     v;
   logic [1:0]        rep;
   logic [ADDR_W-1:0] row_base;
   logic              active, hs_on, vs_on, line_end, frame_end;
   logic [LAT-1:0]    blank_sr, hs_sr, vs_sr;
   logic [23:0]       pix_c;
   logic [23:0]       rgb_d;

   // run holds the counters at (0,0) for one clock after reset so timing restarts cleanly
   always_comb begin
      active    = run && (h < H_ACT) && (v < V_ACT);
      hs_on     = run && (h >= HS_START) && (h < HS_END);
      vs_on     = run && (v >= VS_START) && (v < VS_END);
      line_end  = run && (h == H_LAST);
      frame_end = line_end && (v == V_LAST);
   end

   assign oFRAME_START = run && (h == '0) && (v == '0);

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         run <= 1'b0;
         h   <= '0;
         v   <= '0;
      end else if (!run) begin
         run <= 1'b1;
      end else if (line_end) begin
         h <= '0;
         v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
         h <= h + 1'b1;
      end
   end

   // row_base tracks base + (v>>S)*W; rep counts repeated lines of one source row
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         row_base <= '0;
         rep      <= '0;
         oRD_ADDR <= '0;
      end else begin
         if (frame_end) begin
            row_base <= iFB_BASE;
            rep      <= '0;
         end else if (line_end) begin
            if (rep == REP_LAST) begin
               rep      <= '0;
               row_base <= row_base + ADDR_W'(W);
            end else begin
               rep <= rep + 1'b1;
            end
         end
         if (active)
            oRD_ADDR <= row_base + ADDR_W'(h >> SCALE_LOG2);
      end
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         blank_sr <= '0;
         hs_sr    <= {LAT{~HS_POL}};
         vs_sr    <= {LAT{~VS_POL}};
      end else begin
         blank_sr <= {blank_sr[LAT-2:0], active};
         hs_sr    <= {hs_sr[LAT-2:0], hs_on ? HS_POL : ~HS_POL};
         vs_sr    <= {vs_sr[LAT-2:0], vs_on ? VS_POL : ~VS_POL};
      end
   end

   generate
      if (MODE == 0) begin : g_palette
         logic [23:0] pal [256];
         always_ff @(posedge iVGA_CLK) begin
            if (iPAL_WE)
               pal[iPAL_ADDR] <= iPAL_DATA;
            pix_c <= pal[iRD_DATA];
         end
      end else begin : g_rgb332
         logic unused_pal;
         assign unused_pal = ^{iPAL_WE, iPAL_ADDR, iPAL_DATA};
         always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
            if (!iRST_n)
               pix_c <= '0;
            else
               pix_c <= {iRD_DATA[7:5], iRD_DATA[7:5], iRD_DATA[7:6],
                         iRD_DATA[4:2], iRD_DATA[4:2], iRD_DATA[4:3],
                         {4{iRD_DATA[1:0]}}};
         end
      end
   endgenerate

   // tap LAT-2 of the blank line is aligned with the stage C pixel
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n)
         rgb_d <= '0;
      else
         rgb_d <= blank_sr[LAT-2] ? pix_c : '0;
   end

   assign oR       = rgb_d[23:16];
   assign oG       = rgb_d[15:8];
   assign oB       = rgb_d[7:0];
   assign oHS      = hs_sr[LAT-1];
   assign oVS      = vs_sr[LAT-1];
   assign oBLANK_n = blank_sr[LAT-1];

endmodule
